// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// master: the controller (drives enables, selects, debug state, retired count;
//         receives the IR opcode field).
// slave:  the datapath side (drives opcode, receives the control word).
interface multicycle_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic [6:0]       opcode;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic             PCSource;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal, state, retired
    );

    modport slave (
        output opcode,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal, state, retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V datapath (ld, sd, R-type, beq).
// Ports:
//   clock   - system clock, rising edge
//   reset   - synchronous active-high reset
//   bus     - control bundle (master side): opcode in; enables, mux selects,
//             ALU op class, illegal flag, debug state and retired count out.
// Control outputs are registered: each edge loads the decode of the state
// being entered, so they always match a Moore decode of the state register.
module multicycle_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    multicycle_controller_if.master   bus
);
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ILLEGAL   = 4'd9
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       illegal;
    } ctrl_t;

    state_t           state_q;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] retired_q;
    logic             is_ld_q;

    // Control word for a given state; unlisted fields and unused encodings are 0.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_DECODE:    c.alu_src_b = 2'b10;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_WB:      c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
            end
            S_ILLEGAL:   c.illegal = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

    // Next-state rule; opcode only matters in DECODE, is_ld only in MEM_ADDR.
    function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                          input logic ld);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:    n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LD, OP_SD: n = S_MEM_ADDR;
                    OP_R:         n = S_EXEC_R;
                    OP_BEQ:       n = S_BRANCH;
                    default:      n = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: n = ld ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: n = S_MEM_WB;
            S_EXEC_R:   n = S_R_WB;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    // State, registered control word, ld flag and retired counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode(S_FETCH);
            retired_q <= '0;
            is_ld_q   <= 1'b0;
        end else begin
            state_q <= next_state(state_q, bus.opcode, is_ld_q);
            ctrl_q  <= decode(next_state(state_q, bus.opcode, is_ld_q));
            if (state_q == S_DECODE) begin
                is_ld_q <= (bus.opcode == OP_LD);
            end
            // Final state of every legal instruction retires it on the way out.
            if (state_q == S_MEM_WB || state_q == S_MEM_WRITE ||
                state_q == S_R_WB   || state_q == S_BRANCH) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.PCWrite     = ctrl_q.pc_write;
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.IRWrite     = ctrl_q.ir_write;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.PCSource    = ctrl_q.pc_source;
    assign bus.illegal     = ctrl_q.illegal;
    assign bus.state       = 4'(state_q);
    assign bus.retired     = retired_q;
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RISC-V datapath. It sequences each instruction of the supported subset (ld, sd, add/sub/and/or, beq) through fetch, decode, execute, memory and write-back steps. Per step it drives the datapath enables and mux selects, plus the 2-bit ALU operation class that the ALU control decoder combines with funct7/funct3. It sits directly upstream of the ALU control decoder and alongside the instruction register, PC and register file.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- opcode  in  7  IR[6:0]; sampled only in DECODE
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (branch)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back select: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs1 register
- ALUSrcB  out  2  ALU B select: 00 = rs2 register, 01 = constant 4, 10 = immediate
- ALUOp  out  2  operation class: 00 = add, 01 = subtract/compare, 10 = decode funct fields
- PCSource  out  1  PC input select: 0 = ALU result, 1 = ALUOut
- illegal  out  1  high for exactly the one cycle spent in ILLEGAL
- state  out  4  current state encoding, for debug
- retired  out  CNT_W  count of completed legal instructions

## Operation
State encodings:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, ILLEGAL=9
- Encodings 10–15 are unreachable; if ever entered, the next state is FETCH with all outputs 0.

Output decode:
- Outputs are a pure function of the state register (Moore), except `retired`, which is a register.
- Any output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=0. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 (ld) or 0100011 (sd) → MEM_ADDR
  - 0110011 (R-type) → EXEC_R
  - 1100011 (beq) → BRANCH
  - any other value → ILLEGAL
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEM_READ if the opcode latched in DECODE is ld, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Next state is MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1. Next state is FETCH; `retired` increments.
- MEM_WRITE: MemWrite=1, IorD=1. Next state is FETCH; `retired` increments.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is R_WB.
- R_WB: RegWrite=1, MemtoReg=0. Next state is FETCH; `retired` increments.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Next state is FETCH; `retired` increments.
- ILLEGAL: illegal=1, no write enables asserted. Next state is FETCH; `retired` is unchanged.

Opcode handling:
- The block holds an internal 1-bit flag `is_ld`, captured in DECODE.
- Opcode changes outside DECODE have no effect.

Counter:
- `retired` is CNT_W bits wide and wraps from 2^CNT_W−1 to 0 with no flag.

Invariants:
- MemRead and MemWrite are never high together.
- RegWrite and MemWrite are never high together.
- PCWrite and PCWriteCond are never high together.

## Timing
Reset:
- With reset high at a rising edge: state ← FETCH, `retired` ← 0, `is_ld` ← 0.
- Outputs therefore take the FETCH values after that edge:
  - MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01
  - all other outputs 0, `state`=0
- Reset mid-instruction (any state) abandons the instruction: no increment, next state FETCH. Reset takes priority over every transition and over the counter increment.

Latency in cycles, FETCH through the final state inclusive:
- ld 5
- sd 4
- R-type 4
- beq 3
- illegal 3

Back-to-back operation:
- Instructions issue back-to-back with no idle cycles; the final state is always followed directly by FETCH.

Counter timing:
- `retired` updates on the clock edge that leaves the final state, so the new value is visible in the following FETCH.

## Test plan
- Reset held 2 cycles, then released with opcode=0000011 → state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; retired=1 in the following FETCH.
- opcode=0100011 → states 0,1,2,5,0; MemWrite=1 with IorD=1 only in state 5; RegWrite never 1; retired increments by 1.
- opcode=0110011 then 1100011 back-to-back → states 0,1,6,7,0,1,8,0; ALUOp=10 in state 6 and 01 in state 8; PCWriteCond=1 only in state 8; retired=2.
- opcode=1111111 → states 0,1,9,0; illegal=1 for exactly one cycle; all write enables 0 in state 9; retired unchanged.
- Opcode changed from ld to sd while in MEM_ADDR → still goes to MEM_READ; reset asserted in MEM_READ → next state FETCH, retired unchanged, no MemWrite.
- CNT_W=4: run 16 R-type instructions from reset → retired wraps to 0; invariant checkers (MemRead&MemWrite, RegWrite&MemWrite, PCWrite&PCWriteCond) never fire.
